tdm_demux: RTL
==============

// Module: tdm_demux
// PURPOSE
//   Receive end of the 8:1 TDM serial link; inverse of the 8:1 mux. Accepts one serial bit
//   per enabled clock, aligned by a frame-sync strobe on slot 0, and distributes slot k to
//   output lane k.
//   Presents each completed frame in parallel with a one-cycle frame_valid strobe.
//   Flags sync loss or misalignment.
// PARAMETERS
//   NUM_CH  8   number of lanes (data slots per frame); must be a power of 2, >= 2
//   SEL_W   3   slot-index width, $clog2(NUM_CH)
// PORTS
//   clk          in   1        single clock, rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   en           in   1        slot qualifier; din/sync are sampled only when en=1
//   din          in   1        serial data bit of the current slot
//   sync         in   1        frame sync; high together with the slot-0 bit
//   lane_out     out  NUM_CH   registered frame; bit k = slot k
//   frame_valid  out  1        1-cycle pulse; lane_out updated this cycle
//   slot         out  SEL_W    index of the next slot expected
//   sync_err     out  1        1-cycle pulse on a sync violation
//   parity_err   out  1        1-cycle pulse with frame_valid on parity mismatch (see CONFIG)
// BEHAVIOUR
//   Reset values (async on rst_n=0): lane_out=0, frame_valid=0, sync_err=0, parity_err=0,
//   slot=0, shadow=0, state=HUNT.
//   Cycles with en=0: no state change, slot and shadow hold, and all pulse outputs are 0.
//   FSM states:
//   - HUNT: wait for en&sync.
//     - On en&sync: shadow[0]<=din, slot<=1, go to RUN.
//     - en&!sync: bit discarded, stay in HUNT, no error.
//   - RUN: on each en with slot!=0: shadow[slot]<=din, slot<=slot+1 (wraps to 0).
//     - Frame complete: en at the last slot (slot=NUM_CH-1).
//       - Same edge: lane_out<={din,shadow[NUM_CH-2:0]}, frame_valid=1 for one cycle.
//       - Latency: 1 clk from the sampling edge of the last bit.
//     - en at slot=0:
//       - sync=1: new frame, shadow[0]<=din, slot<=1.
//       - sync=0: sync_err=1, go to HUNT, bit discarded, lane_out holds.
//     - en&sync at slot!=0 (early sync): sync_err=1.
//       - Discard the partial frame; the bit is taken as slot 0 (shadow[0]<=din, slot<=1).
//       - Stay in RUN, no frame_valid.
//   Simultaneous frame completion and sync at the last slot: treat as early sync.
//   - sync_err=1; frame_valid stays 0; that bit starts the new frame.
//   Back-to-back frames are supported with no gap cycle; throughput is 1 frame per NUM_CH en.
//   Reset mid-frame: the partial frame is lost; lane_out reads 0 after reset.
// CONFIGURATION
//   TDM_DEMUX_PARITY_EN defined:
//   - The frame is NUM_CH+1 slots; slot NUM_CH carries even parity over the data slots.
//   - slot widens to $clog2(NUM_CH+1) bits.
//   - frame_valid and the lane_out update move to the parity slot.
//   - parity_err = ^{lane bits, parity bit}, pulsed with frame_valid; lane_out updates anyway.
//   TDM_DEMUX_PARITY_EN undefined:
//   - NUM_CH-slot frame, slot is SEL_W bits.
//   - parity_err port is kept and tied to 0.
// STRUCTURE
//   tdm_pkg (shared with the TX mux side): NUM_CH, SEL_W, state enum {HUNT, RUN},
//   and the parity helper function.
//   Sub-module tdm_slot_counter: slot counter with en, clear-to-1 on sync, wrap, and a
//   last-slot flag.
//   FSM, shadow register and output registers live in tdm_demux.
// TESTING
//   1 Reset, then sync+8 en bits 1,0,1,1,0,0,1,0 (slot 0 first).
//     -> lane_out=8'b0100_1101, frame_valid for exactly 1 cycle.
//   2 Three back-to-back frames 0xA5, 0x3C, 0xFF with en held high.
//     -> three frame_valid pulses 8 clks apart; correct lane_out each time; sync_err never set.
//   3 Frame with en=0 for 2 cycles between slots 3 and 4.
//     -> same lane_out as the gapless frame; slot holds at 4 during the gap.
//   4 Sync at slot 5 mid-frame.
//     -> sync_err pulse; no frame_valid; the next 7 bits complete a new frame.
//   5 Missing sync at the expected slot 0.
//     -> sync_err, state=HUNT; bits are ignored until the next sync; lane_out holds its old value.
//   6 rst_n low at slot 4: outputs are 0 immediately (async).
//     With TDM_DEMUX_PARITY_EN: data 0x01 with parity bit 0 -> parity_err=1 with frame_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants, FSM state type and parity helper for the 8:1 TDM link
// Build option: TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to each frame.
package tdm_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = $clog2(NUM_CH);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int NSLOT  = NUM_CH + 1;
`else
    localparam int NSLOT  = NUM_CH;
`endif
    localparam int SLOT_W = $clog2(NSLOT);
    typedef enum logic {HUNT, RUN} state_t;
    function automatic logic even_par(input logic [NUM_CH-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: frame slot counter with advance, clear-to-1 on sync, wrap and last flag
// Ports: clk, rst_n (async active-low), en (advance one slot), clr (load 1, slot 0 taken),
//        slot (index of next expected slot), last (slot is the final slot of the frame).
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);
    assign last = slot == SLOT_W'(NSLOT - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            slot <= '0;
        else if (clr)
            slot <= SLOT_W'(1);
        else if (en)
            slot <= last ? '0 : slot + 1'b1;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: 8:1 TDM serial receiver, slot k of each sync-aligned frame to lane k
// Ports: clk, rst_n (async active-low), en (slot qualifier), din (serial bit), sync (slot-0 strobe),
//        lane_out (registered frame), frame_valid (1-cycle update pulse), slot (next slot expected),
//        sync_err (1-cycle sync violation pulse), parity_err (1-cycle pulse with frame_valid).
// Build option: TDM_DEMUX_PARITY_EN checks a trailing even-parity slot; otherwise parity_err is 0.
module tdm_demux
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    input  logic              sync,
    output logic [NUM_CH-1:0] lane_out,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              sync_err,
    output logic              parity_err
);
    state_t            state, state_nxt;
    logic [NUM_CH-1:0] shadow, sh_nxt;
    logic [SEL_W-1:0]  idx;
    logic              clr, adv, done, serr, last;

    tdm_slot_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .clr   (clr),
        .slot  (slot),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (state == HUNT)
            state_nxt = clr ? RUN : HUNT;
        else
            state_nxt = (en && !sync && slot == '0) ? HUNT : RUN;
    end

    // A sync always restarts the frame at slot 0, so early sync wins over completion.
    always_comb begin
        clr  = en & sync;
        adv  = en & !sync & (state == RUN) & (slot != '0);
        done = adv & last;
        serr = en & (state == RUN) & (sync ? slot != '0 : slot == '0);
    end

    always_comb begin
        idx         = clr ? '0 : slot[SEL_W-1:0];
        sh_nxt      = shadow;
        sh_nxt[idx] = din;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shadow      <= '0;
            lane_out    <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            if (clr || (adv && !last))
                shadow <= sh_nxt;
`ifdef TDM_DEMUX_PARITY_EN
            if (done)
                lane_out <= shadow;
`else
            if (done)
                lane_out <= sh_nxt;
`endif
            frame_valid <= done;
            sync_err    <= serr;
        end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            parity_err <= 1'b0;
        else
            parity_err <= done & (even_par(shadow) ^ din);
`else
    assign parity_err = 1'b0;
`endif
endmodule
